// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter: FSM encoding, register offsets,
// CTRL field layout and the byte-lane merge helper also used by the bus bridge.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Word offsets, i.e. addr[1:0] for byte offsets 0x0/0x4/0x8/0xC
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_W        = 4;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wr,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wr[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes and a
// maskable, registered interrupt request.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [29:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [31:0]         preset_q, preset_d;
  logic [31:0]         count_q, count_d;
  logic                flag_q, flag_d;
  logic                irq_q;

  logic                wr_any, wr_ctrl, wr_preset;
  logic [31:0]         ctrl_merged;
  logic [1:0]          mode;
  logic                en, oneshot;
  logic                hw_en_clr, flag_set, flag_clr;
  logic                unused_bits;

  assign wr_any      = sel && (|byteen);
  assign wr_ctrl     = wr_any && (addr[1:0] == OFF_CTRL);
  assign wr_preset   = wr_any && (addr[1:0] == OFF_PRESET);
  assign ctrl_merged = byte_merge({{(32-CTRL_W){1'b0}}, ctrl_q}, wdata, byteen);

  assign en      = ctrl_q[CTRL_EN_BIT];
  assign mode    = ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB];
  assign oneshot = (mode == MODE_ONESHOT) || mode[1];

  assign unused_bits = ^{addr[29:2], ctrl_merged[31:CTRL_W]};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hw_en_clr = 1'b0;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          // PRESET=0 lands here too, so the counter never wraps
          count_d  = 32'd0;
          state_d  = ST_INT;
          flag_set = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      ST_INT: begin
        if (oneshot) begin
          hw_en_clr = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          flag_clr = 1'b1;
          state_d  = ST_LOAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Software CTRL writes take priority over hardware EN clear and flag updates
  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    flag_d   = flag_q;
    if (wr_ctrl) begin
      ctrl_d = ctrl_merged[CTRL_W-1:0];
    end else if (hw_en_clr) begin
      ctrl_d[CTRL_EN_BIT] = 1'b0;
    end
    if (wr_preset) preset_d = byte_merge(preset_q, wdata, byteen);
    if (wr_ctrl) begin
      flag_d = 1'b0;
    end else if (flag_set) begin
      flag_d = 1'b1;
    end else if (flag_clr) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= flag_d && ctrl_d[CTRL_IM_BIT];
    end
  end

  assign irq = irq_q;

  always_comb begin
    rdata = 32'd0;
    unique case (addr[1:0])
      OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
      OFF_PRESET: rdata = preset_q;
      OFF_COUNT:  rdata = count_q;
      OFF_RSVD:   rdata = 32'd0;
      default:    rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed scenarios with literal expectations plus a
// randomized phase, all continuously compared against a behavioural model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [29:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  timer_counter dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model: the timer is either idle, waiting one cycle to load,
  // counting down, or spending one cycle firing.
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count;
  logic        m_flag;
  bit          m_loading, m_counting, m_firing;

  logic [3:0]  n_ctrl;
  logic [31:0] n_preset, n_count;
  logic        n_flag;
  bit          n_loading, n_counting, n_firing;

  function automatic logic [31:0] lane_mix(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
      m_loading = 1'b0; m_counting = 1'b0; m_firing = 1'b0;
    end else begin
      n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count; n_flag = m_flag;
      n_loading = 1'b0; n_counting = 1'b0; n_firing = 1'b0;
      if (m_firing) begin
        if (m_ctrl[2:1] == 2'b01) begin
          n_loading = 1'b1;
          n_flag    = 1'b0;
        end else begin
          n_ctrl[0] = 1'b0;
        end
      end else if (m_loading) begin
        n_count    = m_preset;
        n_counting = 1'b1;
      end else if (m_counting) begin
        if (m_ctrl[0]) begin
          if (m_count <= 1) begin
            n_count  = 32'd0;
            n_firing = 1'b1;
            n_flag   = 1'b1;
          end else begin
            n_count    = m_count - 1;
            n_counting = 1'b1;
          end
        end
      end else if (m_ctrl[0]) begin
        n_loading = 1'b1;
      end
      if (sel && byteen != 4'd0) begin
        if (addr[1:0] == 2'd0) begin
          n_ctrl = lane_mix({28'd0, m_ctrl}, wdata, byteen) & 32'hF;
          n_flag = 1'b0;
        end else if (addr[1:0] == 2'd1) begin
          n_preset = lane_mix(m_preset, wdata, byteen);
        end
      end
      m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_flag = n_flag;
      m_loading = n_loading; m_counting = n_counting; m_firing = n_firing;
    end
  end

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    #4;
    if (chk_en) begin
      n_tests++;
      if (irq !== (m_flag & m_ctrl[3])) begin
        n_fail++;
        $display("FAIL cmp_irq t=%0t: got %b expected %b", $time, irq, m_flag & m_ctrl[3]);
      end
      n_tests++;
      if (rdata !== model_read(addr[1:0])) begin
        n_fail++;
        $display("FAIL cmp_rdata t=%0t off=%0d: got %h expected %h",
                 $time, addr[1:0], rdata, model_read(addr[1:0]));
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
    sel = 1'b1; addr = {28'd0, a}; byteen = be; wdata = d;
    tick();
    sel = 1'b0; byteen = 4'd0;
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string nm);
    addr = {28'd0, a};
    #1;
    check(nm, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; addr = '0; byteen = '0; wdata = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    peek(2'd0, 32'd0, "rst_ctrl");
    peek(2'd1, 32'd0, "rst_preset");
    peek(2'd2, 32'd0, "rst_count");
    check("rst_irq", {31'd0, irq}, 32'd0);

    // One-shot, PRESET=5: irq rises 7 edges after the CTRL write and stays
    wr(2'd1, 4'hF, 32'd5);
    wr(2'd0, 4'hF, 32'h9);
    addr = 30'd2;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("oneshot_irq_e%0d", k), {31'd0, irq}, (k == 7) ? 32'd1 : 32'd0);
      if (k == 2) check("oneshot_count_loaded", rdata, 32'd5);
    end
    tick(); tick();
    peek(2'd0, 32'h8, "oneshot_ctrl_en_cleared");
    check("oneshot_irq_held", {31'd0, irq}, 32'd1);
    wr(2'd0, 4'hF, 32'h0);
    check("ctrl_write_clears_irq", {31'd0, irq}, 32'd0);

    // Auto-reload, PRESET=3: 1-cycle pulse every 5 cycles
    wr(2'd1, 4'hF, 32'd3);
    wr(2'd0, 4'hF, 32'hB);
    addr = 30'd2;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("auto_irq_e%0d", k), {31'd0, irq}, (k == 5 || k == 10) ? 32'd1 : 32'd0);
      if (k == 7 || k == 12) check($sformatf("auto_reload_e%0d", k), rdata, 32'd3);
    end
    wr(2'd0, 4'hF, 32'h0);

    // Disable mid-count at COUNT=4, then re-enable reloads from PRESET
    wr(2'd1, 4'hF, 32'd6);
    wr(2'd0, 4'hF, 32'h9);
    tick(); tick(); tick();
    wr(2'd0, 4'hF, 32'h8);
    repeat (4) tick();
    peek(2'd2, 32'd4, "pause_count_held");
    check("pause_no_irq", {31'd0, irq}, 32'd0);
    wr(2'd1, 4'hF, 32'd2);
    wr(2'd0, 4'hF, 32'h9);
    tick(); tick();
    peek(2'd2, 32'd2, "reenable_reload");
    tick(); tick();
    check("reenable_irq", {31'd0, irq}, 32'd1);
    wr(2'd0, 4'hF, 32'h0);

    // Byte-lane merge, read-only COUNT, reserved offset, CTRL upper bits
    wr(2'd1, 4'hF, 32'h11223344);
    wr(2'd1, 4'b0010, 32'h0000AB00);
    peek(2'd1, 32'h1122AB44, "preset_byte_merge");
    wr(2'd1, 4'b0000, 32'hFFFFFFFF);
    peek(2'd1, 32'h1122AB44, "preset_no_byteen");
    wr(2'd2, 4'hF, 32'hFFFFFFFF);
    peek(2'd2, 32'd0, "count_readonly");
    wr(2'd3, 4'hF, 32'hFFFFFFFF);
    peek(2'd3, 32'd0, "rsvd_reads_zero");
    wr(2'd0, 4'hF, 32'hFFFFFFF0);
    peek(2'd0, 32'd0, "ctrl_upper_ignored");

    // PRESET=0 behaves as PRESET=1
    wr(2'd1, 4'hF, 32'd0);
    wr(2'd0, 4'hF, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("preset0_irq_e%0d", k), {31'd0, irq}, (k == 3) ? 32'd1 : 32'd0);
    end
    peek(2'd2, 32'd0, "preset0_no_wrap");
    wr(2'd0, 4'hF, 32'h0);

    // Masked interrupt: expiry without IM leaves irq low
    wr(2'd1, 4'hF, 32'd1);
    wr(2'd0, 4'hF, 32'h1);
    repeat (6) tick();
    check("masked_irq_low", {31'd0, irq}, 32'd0);
    peek(2'd0, 32'd0, "masked_en_cleared");

    // Software CTRL write on the hardware EN-clear cycle wins
    wr(2'd0, 4'hF, 32'h9);
    tick(); tick(); tick();
    wr(2'd0, 4'hF, 32'hB);
    peek(2'd0, 32'hB, "sw_write_beats_hw_clear");
    check("sw_write_clears_flag", {31'd0, irq}, 32'd0);
    wr(2'd0, 4'hF, 32'h0);

    // Reset during counting with a simultaneous CTRL write
    wr(2'd1, 4'hF, 32'd20);
    wr(2'd0, 4'hF, 32'h9);
    repeat (4) tick();
    reset = 1'b1; sel = 1'b1; addr = 30'd0; byteen = 4'hF; wdata = 32'hB;
    tick();
    reset = 1'b0; sel = 1'b0; byteen = 4'd0;
    peek(2'd0, 32'd0, "midrst_ctrl");
    peek(2'd1, 32'd0, "midrst_preset");
    peek(2'd2, 32'd0, "midrst_count");
    check("midrst_irq", {31'd0, irq}, 32'd0);
    repeat (3) tick();
    peek(2'd2, 32'd0, "midrst_stays_idle");

    // Randomized traffic, checked every cycle by the model comparison
    for (int i = 0; i < 4000; i++) begin
      int kind;
      kind   = $urandom_range(0, 15);
      reset  = ($urandom_range(0, 299) == 0);
      addr   = 30'($urandom());
      byteen = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      sel    = 1'b0;
      wdata  = $urandom();
      if (kind == 0) begin
        sel = 1'b1; addr[1:0] = 2'd0;
      end else if (kind == 1) begin
        sel = 1'b1; addr[1:0] = 2'd1;
        if ($urandom_range(0, 3) != 0) wdata = $urandom_range(0, 9);
      end else if (kind == 2) begin
        sel = 1'b1;
      end
      tick();
    end
    reset = 1'b0; sel = 1'b0; byteen = 4'd0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
